// File: rtl/remote_comm.sv
// remote_comm
// Test-side remote controller. Sends a 16-bit command to the robot as two
// 8N1 UART bytes, high byte first. Also receives the robot's one-byte
// response, for example 0xA5 for "done".
//
// Ports
//   clk       system clock, all logic on the rising edge
//   rst_n     synchronous active-low reset
//   RX        serial line from the robot (asynchronous, idle high)
//   TX        serial line to the robot (idle high)
//   cmd       command word, sampled when send_cmd is accepted
//   send_cmd  one-cycle request to transmit cmd (ignored unless idle)
//   cmd_sent  level, set once both bytes have been fully shifted out
//   resp_rdy  level, set when a response byte has been received
//   resp      last received byte
//
// Sequencer states
//   state   | meaning
//   IDLE    | waiting for send_cmd; cmd_sent shows the last command's status
//   SEND_HI | transmitting cmd[15:8]
//   SEND_LO | transmitting the latched cmd[7:0]
module remote_comm #(
   parameter int BAUD_DIV = 2604
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        RX,
   output logic        TX,
   input  logic [15:0] cmd,
   input  logic        send_cmd,
   output logic        cmd_sent,
   output logic        resp_rdy,
   output logic [7:0]  resp
);

   localparam logic [11:0] BAUD_FULL = 12'(BAUD_DIV - 1);
   localparam logic [11:0] BAUD_HALF = 12'(BAUD_DIV / 2 - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_HI = 2'd1,
      SEND_LO = 2'd2
   } seq_state_t;

   seq_state_t  state_q, state_d;

   logic        tx_load;
   logic [7:0]  tx_byte;
   logic        tx_done;
   logic        cmd_accept;
   logic        sent_set;
   logic [7:0]  cmd_lo_q;

   // ---------------------------------------------------------------
   // Send sequencer
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d    = state_q;
      tx_load    = 1'b0;
      tx_byte    = 8'h00;
      cmd_accept = 1'b0;
      sent_set   = 1'b0;
      case (state_q)
         IDLE: begin
            if (send_cmd) begin
               cmd_accept = 1'b1;
               tx_load    = 1'b1;
               tx_byte    = cmd[15:8];
               state_d    = SEND_HI;
            end
         end
         SEND_HI: begin
            // Reloading on the final stop-bit cycle lets the low byte's
            // start bit follow the high byte's stop bit with no idle gap.
            if (tx_done) begin
               tx_load = 1'b1;
               tx_byte = cmd_lo_q;
               state_d = SEND_LO;
            end
         end
         SEND_LO: begin
            if (tx_done) begin
               sent_set = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // The high byte is handed to the transmitter directly on acceptance,
   // so only the low byte has to be held for the second transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cmd_lo_q <= 8'h00;
         cmd_sent <= 1'b0;
      end else if (cmd_accept) begin
         cmd_lo_q <= cmd[7:0];
         cmd_sent <= 1'b0;
      end else if (sent_set) begin
         cmd_sent <= 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // UART transmitter, 8N1
   // ---------------------------------------------------------------
   logic [11:0] tx_baud_q;
   logic [3:0]  tx_bits_q;
   logic [8:0]  tx_sr_q;
   logic        tx_busy_q;
   logic        tx_q;

   // tx_bits_q counts the bits still to go after the current one, so
   // zero with an expired baud count marks the last cycle of the stop bit.
   assign tx_done = tx_busy_q && (tx_baud_q == 12'd0) && (tx_bits_q == 4'd0);
   assign TX      = tx_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_q      <= 1'b1;
         tx_busy_q <= 1'b0;
         tx_baud_q <= 12'd0;
         tx_bits_q <= 4'd0;
         tx_sr_q   <= 9'h1FF;
      end else if (tx_load) begin
         tx_q      <= 1'b0;
         tx_sr_q   <= {1'b1, tx_byte};
         tx_baud_q <= BAUD_FULL;
         tx_bits_q <= 4'd9;
         tx_busy_q <= 1'b1;
      end else if (tx_busy_q) begin
         if (tx_baud_q != 12'd0) begin
            tx_baud_q <= tx_baud_q - 12'd1;
         end else if (tx_bits_q == 4'd0) begin
            tx_busy_q <= 1'b0;
         end else begin
            tx_q      <= tx_sr_q[0];
            tx_sr_q   <= {1'b1, tx_sr_q[8:1]};
            tx_bits_q <= tx_bits_q - 4'd1;
            tx_baud_q <= BAUD_FULL;
         end
      end
   end

   // ---------------------------------------------------------------
   // UART receiver
   // ---------------------------------------------------------------
   logic        rx_meta_q, rx_sync_q, rx_prev_q;
   logic        rx_busy_q;
   logic [11:0] rx_baud_q;
   logic [3:0]  rx_bits_q;
   logic [7:0]  rx_sr_q;
   logic        rx_start;
   logic        rx_sample;
   logic        rx_last;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= RX;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign rx_start  = !rx_busy_q && rx_prev_q && !rx_sync_q;
   assign rx_sample = rx_busy_q && (rx_baud_q == 12'd0);
   // Ten sample points: start, eight data bits, stop. The first nine shift;
   // the stop-bit midpoint only publishes the byte and frees the receiver,
   // so a back-to-back start bit can be caught right after it.
   assign rx_last   = rx_sample && (rx_bits_q == 4'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rx_busy_q <= 1'b0;
         rx_baud_q <= 12'd0;
         rx_bits_q <= 4'd0;
         rx_sr_q   <= 8'h00;
         resp      <= 8'h00;
         resp_rdy  <= 1'b0;
      end else begin
         if (rx_start) begin
            rx_busy_q <= 1'b1;
            rx_baud_q <= BAUD_HALF;
            rx_bits_q <= 4'd10;
         end else if (rx_sample) begin
            rx_bits_q <= rx_bits_q - 4'd1;
            rx_baud_q <= BAUD_FULL;
            if (rx_last) begin
               rx_busy_q <= 1'b0;
               resp      <= rx_sr_q;
            end else begin
               // Nine shifts through eight bits push the start bit out.
               rx_sr_q <= {rx_sync_q, rx_sr_q[7:1]};
            end
         end else if (rx_busy_q) begin
            rx_baud_q <= rx_baud_q - 12'd1;
         end

         if (rx_last)
            resp_rdy <= 1'b1;
         else if (rx_start || cmd_accept)
            resp_rdy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_remote_comm.sv
module tb_remote_comm;

   localparam int D = 16;

   logic        clk;
   logic        rst_n;
   logic        rx_line;
   logic        rx_tb;
   logic        loop_en;
   logic        TX;
   logic [15:0] cmd;
   logic        send_cmd;
   logic        cmd_sent;
   logic        resp_rdy;
   logic [7:0]  resp;

   int          n_checks = 0;
   int          n_fail   = 0;
   bit          tx_abort = 0;

   logic [7:0]  exp_tx[$];
   logic [7:0]  exp_resp[$];

   assign rx_line = loop_en ? TX : rx_tb;

   remote_comm #(.BAUD_DIV(D)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .RX       (rx_line),
      .TX       (TX),
      .cmd      (cmd),
      .send_cmd (send_cmd),
      .cmd_sent (cmd_sent),
      .resp_rdy (resp_rdy),
      .resp     (resp)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_range(input string name, input int val, input int lo, input int hi);
      n_checks++;
      if (val < lo || val > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d cycles, expected %0d..%0d", name, val, lo, hi);
      end
   endtask

   task automatic issue_cmd(input logic [15:0] c);
      @(posedge clk); #1;
      cmd      = c;
      send_cmd = 1'b1;
      @(posedge clk); #1;
      send_cmd = 1'b0;
   endtask

   // Counts cycles from the accepting edge until cmd_sent is seen.
   // 'already' is the number of cycles since acceptance when called.
   task automatic wait_sent(input string name, input int already);
      int n;
      n = already;
      while (cmd_sent !== 1'b1 && n < 25 * D) begin
         @(posedge clk); #1;
         n++;
      end
      check_range(name, n, 20 * D - 2, 20 * D + 2);
   endtask

   task automatic rx_send(input logic [7:0] b);
      logic [9:0] frame;
      frame = {1'b1, b, 1'b0};
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         rx_tb = frame[i];
         repeat (D) @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input string name, input int bound);
      int n;
      n = 0;
      while ((exp_tx.size() != 0 || exp_resp.size() != 0) && n < bound) begin
         @(posedge clk);
         n++;
      end
      check(name, 16'(exp_tx.size() + exp_resp.size()), 16'h0000);
   endtask

   // TX line monitor: decodes each 8N1 frame, sampling mid-bit.
   initial begin
      logic [7:0] data;
      logic       start_b, stop_b;
      forever begin
         @(negedge clk);
         if (TX === 1'b0) begin
            tx_abort = 1'b0;
            repeat (D / 2) @(negedge clk);
            start_b = TX;
            for (int i = 0; i < 8; i++) begin
               repeat (D) @(negedge clk);
               data[i] = TX;
            end
            repeat (D) @(negedge clk);
            stop_b = TX;
            if (!tx_abort) begin
               if (exp_tx.size() == 0) begin
                  check("tx_unexpected_byte", 16'(data), 16'hFFFF);
               end else begin
                  check("tx_byte", 16'(data), 16'(exp_tx.pop_front()));
                  check("tx_start_bit", 16'(start_b), 16'h0000);
                  check("tx_stop_bit", 16'(stop_b), 16'h0001);
               end
            end
         end
      end
   end

   // Response monitor: every rising edge of resp_rdy delivers one byte.
   initial begin
      logic prev_rdy;
      prev_rdy = 1'b0;
      forever begin
         @(negedge clk);
         if (resp_rdy === 1'b1 && prev_rdy !== 1'b1) begin
            if (exp_resp.size() == 0)
               check("resp_unexpected", 16'(resp), 16'hFFFF);
            else
               check("resp_byte", 16'(resp), 16'(exp_resp.pop_front()));
         end
         prev_rdy = resp_rdy;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst_n    = 1'b0;
      rx_tb    = 1'b1;
      loop_en  = 1'b0;
      send_cmd = 1'b0;
      cmd      = 16'h0000;

      // Reset values
      repeat (3) @(posedge clk); #1;
      check("rst_tx", 16'(TX), 16'h0001);
      check("rst_cmd_sent", 16'(cmd_sent), 16'h0000);
      check("rst_resp_rdy", 16'(resp_rdy), 16'h0000);
      check("rst_resp", 16'(resp), 16'h0000);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Command 0x2000 -> bytes 0x20, 0x00
      exp_tx.push_back(8'h20);
      exp_tx.push_back(8'h00);
      issue_cmd(16'h2000);
      check("t1_cmd_sent_low", 16'(cmd_sent), 16'h0000);
      wait_sent("t1_cmd_sent_latency", 0);
      wait_drain("t1_drain", 4 * D);

      // Response 0xA5 on RX. resp_rdy is expected 9.5 bit times after the
      // start edge plus 3 cycles for the two sync flops and edge detect.
      exp_resp.push_back(8'hA5);
      fork
         rx_send(8'hA5);
         begin
            n = 0;
            @(posedge clk); #1;
            while (resp_rdy !== 1'b1 && n < 12 * D) begin
               @(posedge clk); #1;
               n++;
            end
            check_range("t2_resp_rdy_time", n, 9 * D + D / 2 + 3 - 1, 9 * D + D / 2 + 3 + 1);
         end
      join
      check("t2_resp", 16'(resp), 16'h00A5);

      // send_cmd while resp_rdy is set clears it; resp keeps 0xA5
      check("t6_rdy_before", 16'(resp_rdy), 16'h0001);
      exp_tx.push_back(8'h12);
      exp_tx.push_back(8'h34);
      issue_cmd(16'h1234);
      check("t6_rdy_cleared", 16'(resp_rdy), 16'h0000);
      check("t6_cmd_sent_cleared", 16'(cmd_sent), 16'h0000);
      check("t6_resp_hold", 16'(resp), 16'h00A5);
      wait_sent("t6_cmd_sent_latency", 0);
      check("t6_resp_hold_end", 16'(resp), 16'h00A5);
      wait_drain("t6_drain", 4 * D);

      // Command 0x43F2 with loopback; a second send_cmd mid-transfer is ignored
      loop_en = 1'b1;
      exp_tx.push_back(8'h43);
      exp_tx.push_back(8'hF2);
      exp_resp.push_back(8'h43);
      exp_resp.push_back(8'hF2);
      issue_cmd(16'h43F2);
      repeat (5 * D) @(posedge clk);
      issue_cmd(16'hFFFF);
      wait_sent("t3_cmd_sent_latency", 5 * D + 2);
      wait_drain("t3_drain", 4 * D);
      check("t4_resp_last", 16'(resp), 16'h00F2);
      loop_en = 1'b0;
      repeat (2 * D) @(posedge clk);

      // Reset in the middle of a TX byte while resp_rdy is set
      exp_resp.push_back(8'h3C);
      fork
         rx_send(8'h3C);
         begin
            repeat (2 * D) @(posedge clk);
            issue_cmd(16'h00C3);
            repeat (8 * D + D / 2) @(posedge clk);
            #1;
            check("t5_tx_low_before", 16'(TX), 16'h0000);
            check("t5_rdy_before", 16'(resp_rdy), 16'h0001);
            rst_n    = 1'b0;
            tx_abort = 1'b1;
            @(posedge clk); #1;
            check("t5_rst_tx", 16'(TX), 16'h0001);
            check("t5_rst_cmd_sent", 16'(cmd_sent), 16'h0000);
            check("t5_rst_resp_rdy", 16'(resp_rdy), 16'h0000);
            check("t5_rst_resp", 16'(resp), 16'h0000);
            @(posedge clk); #1;
            rst_n = 1'b1;
         end
      join
      check("t5_exp_resp_seen", 16'(exp_resp.size()), 16'h0000);
      repeat (4 * D) @(posedge clk);

      // Fresh command after the abort
      exp_tx.push_back(8'h5A);
      exp_tx.push_back(8'h3C);
      issue_cmd(16'h5A3C);
      wait_sent("t5_fresh_cmd_latency", 0);
      wait_drain("t5_drain", 4 * D);
      check("t5_tx_idle", 16'(TX), 16'h0001);

      repeat (D) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
